// File: rtl/gol_frame_scheduler_if.sv
// Bundle between the Game of Life frame scheduler and its neighbours: register file,
// compute engine, pixel streamer and the two line BRAMs.
interface gol_frame_scheduler_if #(
  parameter int ADDR_W = 10
);
  logic              pause;
  logic              init_start;
  // Handshakes: a row moves on the edge where valid and ready are both 1.
  // Ready depends only on scheduler state, never on valid.
  logic              init_row_valid;
  logic              init_row_ready;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_row;
  logic              disp_frame_end;
  logic              disp_line_valid;
  logic              calc_rd_ready;
  logic              calc_line_valid;
  logic [ADDR_W-1:0] calc_line_row;
  logic              res_valid;
  logic              res_ready;
  logic [ADDR_W-1:0] bram_a_addr;
  logic [ADDR_W-1:0] bram_b_addr;
  logic              bram_a_we;
  logic              bram_b_we;
  logic              front_sel;
  logic [31:0]       gen_count;
  logic [2:0]        sched_state;

  modport slave (
    input  pause, init_start, init_row_valid, disp_req, disp_row, disp_frame_end,
           calc_rd_ready, res_valid,
    output init_row_ready, disp_line_valid, calc_line_valid, calc_line_row, res_ready,
           bram_a_addr, bram_b_addr, bram_a_we, bram_b_we, front_sel, gen_count,
           sched_state
  );

  modport master (
    output pause, init_start, init_row_valid, disp_req, disp_row, disp_frame_end,
           calc_rd_ready, res_valid,
    input  init_row_ready, disp_line_valid, calc_line_valid, calc_line_row, res_ready,
           bram_a_addr, bram_b_addr, bram_a_we, bram_b_we, front_sel, gen_count,
           sched_state
  );
endinterface

// File: rtl/gol_frame_scheduler.sv
// Owns front/back bank selection for the two Game of Life line BRAMs, arbitrates the
// front read port between display and compute, and swaps banks only at frame ends.
module gol_frame_scheduler #(
  parameter int Y_SIZE = 720,
  parameter int ADDR_W = 10
) (
  input logic                  out_stream_aclk,
  input logic                  periph_reset,
  gol_frame_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INIT      = 3'd1,
    S_COMPUTE   = 3'd2,
    S_WAIT_SWAP = 3'd3,
    S_PAUSED    = 3'd4
  } state_t;

  localparam int                SEQ_W    = ADDR_W + 2;
  localparam logic [SEQ_W-1:0]  SEQ_LAST = SEQ_W'(Y_SIZE + 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(Y_SIZE - 1);

  state_t            state;
  logic              front_sel;
  logic [31:0]       gen_count;
  logic [ADDR_W-1:0] wr_row;
  logic [SEQ_W-1:0]  rd_seq;
  logic              from_compute;
  logic              disp_line_valid;
  logic              calc_line_valid;
  logic [ADDR_W-1:0] calc_line_row;

  logic              init_fire;
  logic              res_fire;
  logic              wr_fire;
  logic              rd_grant;
  logic [ADDR_W-1:0] rd_row;
  logic [ADDR_W-1:0] front_addr;
  logic [ADDR_W-1:0] back_addr;

  always_comb begin
    init_fire = (state == S_INIT) && bus.init_row_valid;
    res_fire  = (state == S_COMPUTE) && bus.res_valid;
    wr_fire   = init_fire || res_fire;
    rd_grant  = (state == S_COMPUTE) && bus.calc_rd_ready && (rd_seq <= SEQ_LAST) &&
                !bus.disp_req;
    // Source rows are read with a toroidal halo: last row first, row 0 again at the end.
    if (rd_seq == '0) begin
      rd_row = ROW_LAST;
    end else if (rd_seq == SEQ_LAST) begin
      rd_row = '0;
    end else begin
      rd_row = ADDR_W'(rd_seq - 1'b1);
    end
    front_addr = bus.disp_req ? bus.disp_row : (rd_grant ? rd_row : '0);
    back_addr  = wr_row;
  end

  assign bus.init_row_ready  = (state == S_INIT);
  assign bus.res_ready       = (state == S_COMPUTE);
  assign bus.bram_a_addr     = front_sel ? back_addr : front_addr;
  assign bus.bram_b_addr     = front_sel ? front_addr : back_addr;
  assign bus.bram_a_we       = front_sel && wr_fire;
  assign bus.bram_b_we       = !front_sel && wr_fire;
  assign bus.front_sel       = front_sel;
  assign bus.gen_count       = gen_count;
  assign bus.sched_state     = state;
  assign bus.disp_line_valid = disp_line_valid;
  assign bus.calc_line_valid = calc_line_valid;
  assign bus.calc_line_row   = calc_line_row;

  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      state           <= S_IDLE;
      front_sel       <= 1'b0;
      gen_count       <= '0;
      wr_row          <= '0;
      rd_seq          <= '0;
      from_compute    <= 1'b0;
      disp_line_valid <= 1'b0;
      calc_line_valid <= 1'b0;
      calc_line_row   <= '0;
    end else begin
      disp_line_valid <= bus.disp_req;
      calc_line_valid <= rd_grant;
      if (rd_grant) begin
        calc_line_row <= rd_row;
        rd_seq        <= rd_seq + 1'b1;
      end
      if (wr_fire) begin
        wr_row <= wr_row + 1'b1;
      end

      // A host load overrides everything, abandoning any generation in flight.
      if (bus.init_start) begin
        state        <= S_INIT;
        wr_row       <= '0;
        rd_seq       <= '0;
        from_compute <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_INIT: begin
            if (init_fire && (wr_row == ROW_LAST)) begin
              state        <= S_WAIT_SWAP;
              from_compute <= 1'b0;
            end
          end
          S_COMPUTE: begin
            if (res_fire && (wr_row == ROW_LAST)) begin
              state        <= S_WAIT_SWAP;
              from_compute <= 1'b1;
            end
          end
          S_WAIT_SWAP: begin
            if (bus.disp_frame_end) begin
              front_sel <= !front_sel;
              if (from_compute) begin
                gen_count <= gen_count + 32'd1;
              end
              if (bus.pause) begin
                state <= S_PAUSED;
              end else begin
                state  <= S_COMPUTE;
                wr_row <= '0;
                rd_seq <= '0;
              end
            end
          end
          S_PAUSED: begin
            if (!bus.pause) begin
              state  <= S_COMPUTE;
              wr_row <= '0;
              rd_seq <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gol_frame_scheduler.sv
// Directed bench for gol_frame_scheduler with a 4-row frame: load, swap, halo read
// order, display stalls, result writes, pause, abort and mid-run reset.
module tb_gol_frame_scheduler;

  localparam int Y_SIZE = 4;
  localparam int ADDR_W = 10;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  gol_frame_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  gol_frame_scheduler #(.Y_SIZE(Y_SIZE), .ADDR_W(ADDR_W)) dut (
    .out_stream_aclk (clk),
    .periph_reset    (rst),
    .bus             (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] tail_rows [4];
    tail_rows = '{10'd1, 10'd2, 10'd3, 10'd0};
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.pause = 1'b0;
    bus.init_start = 1'b0;
    bus.init_row_valid = 1'b0;
    bus.disp_req = 1'b0;
    bus.disp_row = '0;
    bus.disp_frame_end = 1'b0;
    bus.calc_rd_ready = 1'b0;
    bus.res_valid = 1'b0;
    tick();
    tick();

    chk("rst_state", 32'(bus.sched_state), 32'd0);
    chk("rst_front_sel", 32'(bus.front_sel), 32'd0);
    chk("rst_gen", bus.gen_count, 32'd0);
    chk("rst_addr", 32'({bus.bram_a_addr, bus.bram_b_addr}), 32'd0);
    chk("rst_we", 32'({bus.bram_a_we, bus.bram_b_we}), 32'd0);
    chk("rst_ready", 32'({bus.init_row_ready, bus.res_ready}), 32'd0);
    chk("rst_valid", 32'({bus.disp_line_valid, bus.calc_line_valid}), 32'd0);
    chk("rst_calc_row", 32'(bus.calc_line_row), 32'd0);
    rst = 1'b0;
    tick();

    // Display reads are served from bank A while idle.
    bus.disp_req = 1'b1;
    bus.disp_row = 10'd9;
    #1;
    chk("idle_disp_addr", 32'(bus.bram_a_addr), 32'd9);
    tick();
    bus.disp_req = 1'b0;
    chk("idle_disp_valid", 32'(bus.disp_line_valid), 32'd1);
    chk("idle_state", 32'(bus.sched_state), 32'd0);

    // Host load into back bank B.
    bus.init_start = 1'b1;
    tick();
    bus.init_start = 1'b0;
    chk("init_state", 32'(bus.sched_state), 32'd1);
    chk("init_ready", 32'(bus.init_row_ready), 32'd1);
    chk("init_idle_we", 32'(bus.bram_b_we), 32'd0);
    for (int r = 0; r < Y_SIZE; r++) begin
      bus.init_row_valid = 1'b1;
      #1;
      chk("init_b_we", 32'(bus.bram_b_we), 32'd1);
      chk("init_b_addr", 32'(bus.bram_b_addr), 32'(r));
      chk("init_a_we", 32'(bus.bram_a_we), 32'd0);
      tick();
    end
    bus.init_row_valid = 1'b0;
    chk("load_done_state", 32'(bus.sched_state), 32'd3);
    chk("load_front_sel", 32'(bus.front_sel), 32'd0);
    tick();
    chk("wait_hold_state", 32'(bus.sched_state), 32'd3);
    bus.disp_frame_end = 1'b1;
    tick();
    bus.disp_frame_end = 1'b0;
    chk("swap1_front_sel", 32'(bus.front_sel), 32'd1);
    chk("swap1_state", 32'(bus.sched_state), 32'd2);
    chk("swap1_gen", bus.gen_count, 32'd0);

    // Source reads from front bank B: 3,0 then a 3-cycle display stall, then 1,2,3,0.
    bus.calc_rd_ready = 1'b1;
    #1;
    chk("rd_addr0", 32'(bus.bram_b_addr), 32'd3);
    chk("rd_a_we", 32'(bus.bram_a_we), 32'd0);
    tick();
    chk("rd_valid0", 32'(bus.calc_line_valid), 32'd1);
    chk("rd_row0", 32'(bus.calc_line_row), 32'd3);
    #1;
    chk("rd_addr1", 32'(bus.bram_b_addr), 32'd0);
    tick();
    chk("rd_valid1", 32'(bus.calc_line_valid), 32'd1);
    chk("rd_row1", 32'(bus.calc_line_row), 32'd0);
    for (int k = 0; k < 3; k++) begin
      bus.disp_req = 1'b1;
      bus.disp_row = 10'(5 + k);
      #1;
      chk("stall_addr", 32'(bus.bram_b_addr), 32'(5 + k));
      tick();
      chk("stall_disp_valid", 32'(bus.disp_line_valid), 32'd1);
      chk("stall_calc_valid", 32'(bus.calc_line_valid), 32'd0);
    end
    bus.disp_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rd_tail_addr", 32'(bus.bram_b_addr), 32'(tail_rows[i]));
      tick();
      chk("rd_tail_valid", 32'(bus.calc_line_valid), 32'd1);
      chk("rd_tail_row", 32'(bus.calc_line_row), 32'(tail_rows[i]));
      if (i == 0) chk("rd_disp_drop", 32'(bus.disp_line_valid), 32'd0);
    end
    tick();
    chk("rd_end_valid", 32'(bus.calc_line_valid), 32'd0);
    bus.calc_rd_ready = 1'b0;

    // Results into back bank A; frame end coincides with the last write and is ignored.
    for (int r = 0; r < Y_SIZE; r++) begin
      bus.res_valid = 1'b1;
      bus.disp_frame_end = (r == Y_SIZE - 1);
      #1;
      chk("res_a_we", 32'(bus.bram_a_we), 32'd1);
      chk("res_a_addr", 32'(bus.bram_a_addr), 32'(r));
      chk("res_b_we", 32'(bus.bram_b_we), 32'd0);
      tick();
    end
    bus.res_valid = 1'b0;
    bus.disp_frame_end = 1'b0;
    chk("res_done_state", 32'(bus.sched_state), 32'd3);
    chk("noswap_front_sel", 32'(bus.front_sel), 32'd1);
    chk("noswap_gen", bus.gen_count, 32'd0);
    tick();
    tick();
    chk("noswap_hold_state", 32'(bus.sched_state), 32'd3);
    chk("noswap_hold_front", 32'(bus.front_sel), 32'd1);
    bus.pause = 1'b1;
    bus.disp_frame_end = 1'b1;
    tick();
    bus.disp_frame_end = 1'b0;
    chk("swap2_front_sel", 32'(bus.front_sel), 32'd0);
    chk("swap2_gen", bus.gen_count, 32'd1);
    chk("swap2_state", 32'(bus.sched_state), 32'd4);
    bus.disp_frame_end = 1'b1;
    tick();
    bus.disp_frame_end = 1'b0;
    chk("paused_state", 32'(bus.sched_state), 32'd4);
    chk("paused_front", 32'(bus.front_sel), 32'd0);
    chk("paused_gen", bus.gen_count, 32'd1);
    chk("paused_res_ready", 32'(bus.res_ready), 32'd0);
    bus.pause = 1'b0;
    tick();
    chk("resume_state", 32'(bus.sched_state), 32'd2);
    chk("resume_front", 32'(bus.front_sel), 32'd0);

    // Abort after two results: back to INIT, no swap, count kept.
    for (int r = 0; r < 2; r++) begin
      bus.res_valid = 1'b1;
      #1;
      chk("abort_b_we", 32'(bus.bram_b_we), 32'd1);
      chk("abort_b_addr", 32'(bus.bram_b_addr), 32'(r));
      tick();
    end
    bus.res_valid = 1'b0;
    bus.init_start = 1'b1;
    tick();
    bus.init_start = 1'b0;
    chk("abort_state", 32'(bus.sched_state), 32'd1);
    chk("abort_wr_row", 32'(bus.bram_b_addr), 32'd0);
    chk("abort_gen", bus.gen_count, 32'd1);
    chk("abort_front", 32'(bus.front_sel), 32'd0);
    bus.disp_frame_end = 1'b1;
    tick();
    bus.disp_frame_end = 1'b0;
    chk("init_ignore_fe_state", 32'(bus.sched_state), 32'd1);
    chk("init_ignore_fe_front", 32'(bus.front_sel), 32'd0);

    // Reset mid-run discards progress.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_state", 32'(bus.sched_state), 32'd0);
    chk("midrst_gen", bus.gen_count, 32'd0);
    chk("midrst_front", 32'(bus.front_sel), 32'd0);
    chk("midrst_ready", 32'(bus.init_row_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gol_frame_scheduler.md
# gol_frame_scheduler

Sequences and arbitrates the two single-port 1280-bit line BRAMs (bank A, bank B) that hold the Game of Life front and back frames. It sits between the AXI-Lite register file, the next-state compute engine and the pixel streamer. It owns which bank is displayed and which is written, grants each BRAM port per cycle, and swaps banks only at a display frame boundary. It does not move line data; external muxes are steered by `front_sel`.

## Interface
- `Y_SIZE`, 720, rows per frame.
- `ADDR_W`, 10, BRAM row address width; `Y_SIZE` ≤ 2^`ADDR_W`.
- `out_stream_aclk`  in  1  the single clock; every port is synchronous to it.
- `periph_reset`  in  1  synchronous, active-high reset.
- `pause`  in  1  level; 1 inhibits the start of a new generation.
- `init_start`  in  1  pulse; begins a host load of a full frame.
- `init_row_valid` / `init_row_ready`  in/out  1  host row-write handshake; rows arrive in order 0..Y_SIZE-1.
- `disp_req`  in  1  pixel streamer requests front-bank row `disp_row`.
- `disp_row`  in  ADDR_W  row requested by the streamer.
- `disp_frame_end`  in  1  pulse on the last pixel of a frame.
- `disp_line_valid`  out  1  front-bank douta holds `disp_row` data.
- `calc_rd_ready`  in  1  compute engine can accept a source line.
- `calc_line_valid`  out  1  front-bank douta holds source row `calc_line_row`.
- `calc_line_row`  out  ADDR_W  row index of the delivered source line.
- `res_valid` / `res_ready`  in/out  1  result-row handshake; results arrive in order 0..Y_SIZE-1.
- `bram_a_addr`, `bram_b_addr`  out  ADDR_W  bank addresses.
- `bram_a_we`, `bram_b_we`  out  1  bank write enables.
- `front_sel`  out  1  0: A is front (displayed/read), B is back (written); 1: swapped.
- `gen_count`  out  32  completed generations since reset.
- `sched_state`  out  3  current FSM state, for register readback.

## Operation
- States: IDLE, INIT, COMPUTE, WAIT_SWAP, PAUSED.
- IDLE: `init_start` → INIT. No writes are issued. Display reads are served.
- INIT: `init_row_ready`=1. Each accepted row writes the back bank at row counter `wr_row`, which then increments. The write of row Y_SIZE-1 → WAIT_SWAP.
- COMPUTE:
  - Read sequence counter `rd_seq` runs 0..Y_SIZE+1. Issued row = Y_SIZE-1 when `rd_seq`=0, 0 when `rd_seq`=Y_SIZE+1, otherwise `rd_seq`-1 (toroidal wrap).
  - A read is issued when `calc_rd_ready`=1, `rd_seq`≤Y_SIZE+1 and `disp_req`=0.
  - `res_ready`=1. Each accepted result writes the back bank at `wr_row`. The write of row Y_SIZE-1 → WAIT_SWAP.
- WAIT_SWAP: the cycle after `disp_frame_end`=1:
  - toggle `front_sel`;
  - increment `gen_count` only when arriving from COMPUTE;
  - → PAUSED if `pause`=1, else COMPUTE.
- PAUSED: `init_start` → INIT; else `pause`=0 → COMPUTE.
- Entering INIT or COMPUTE clears `wr_row` and `rd_seq`.
- `init_start` has priority over every other transition in every state. In COMPUTE or WAIT_SWAP it aborts the generation: no swap, `gen_count` unchanged.
- Front-port arbitration: `disp_req` always wins. A compute read stalls while `disp_req`=1. Front bank write enable is always 0.
- Back-port: only the write path drives it. Address = `wr_row`, and the write enable equals the accepted handshake. INIT and COMPUTE are exclusive, so there is no conflict.

## Timing
- Reset values:
  - state IDLE, `front_sel`=0, `gen_count`=0;
  - all addresses 0, all write enables 0;
  - `init_row_ready`=`res_ready`=0, `disp_line_valid`=`calc_line_valid`=0, `calc_line_row`=0.
- Reset asserted mid-generation takes effect at the next edge and discards all progress.
- BRAM read latency is 1 cycle:
  - `disp_line_valid` is asserted in the cycle after `disp_req`;
  - `calc_line_valid`/`calc_line_row` are asserted in the cycle after a granted compute read.
- Addresses and write enables are combinational from the registered state and the current handshake inputs. A write commits on the same edge as the handshake.
- `init_row_ready`/`res_ready` are functions of state only and never depend on `*_valid`.
- A `disp_frame_end` arriving in the same cycle as the last write is not used. The swap waits for the next frame end.
- `front_sel` changes only on the edge after a sampled `disp_frame_end`. The streamer therefore never sees a bank change mid-frame.
- `gen_count` wraps from 2^32-1 to 0.

## Test plan
- Y_SIZE=4, reset, `init_start`, 4 host rows (back-to-back valid) → `bram_b_we` asserted at addr 0,1,2,3. The cycle after the next `disp_frame_end`, `front_sel`=1 and state=COMPUTE.
- COMPUTE with `front_sel`=1, `calc_rd_ready`=1, `disp_req`=0 → `bram_b_addr` sequence 3,0,1,2,3,0. Each `calc_line_valid` is 1 cycle later with matching `calc_line_row`.
- `disp_req` held high for 3 cycles mid-COMPUTE → compute read stalls exactly 3 cycles. `disp_line_valid` follows each request by 1 cycle. The read sequence resumes with no skipped or duplicated row.
- 4 results accepted, then `disp_frame_end` → `front_sel` toggles and `gen_count` goes 0→1. With `pause`=1 held, state=PAUSED and it stays there across further frame ends.
- `init_start` mid-COMPUTE after 2 results → state=INIT, `wr_row`=0, `gen_count` unchanged, no swap.
- Last result and `disp_frame_end` in the same cycle → no swap on that frame. The swap occurs 1 cycle after the following `disp_frame_end`.
